// File: rtl/cpri_rx_pkg.sv
// Shared types and default timing constants for the CPRI receive scheduler.
package cpri_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_READ = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int CHIP_LEN_DEF = 84;
  localparam int RD_LAT_DEF   = 3;
  localparam int GAP_CYC_DEF  = 2;
  localparam int BEAT_W       = 7;

endpackage

// File: rtl/cpri_rx_sched_rr_arbiter.sv
// Mask-and-rotate round-robin arbiter: lowest request above the last grant wins,
// otherwise the lowest request overall. Grant is one-hot.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          any
);

  logic [N-1:0] upper;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick;

  for (genvar gi = 0; gi < N; gi++) begin : g_upper
    assign upper[gi] = (gi > int'(last));
  end

  assign req_hi = req & upper;
  assign pick   = (req_hi != '0) ? req_hi : req;
  // Isolate the lowest set bit of the selected request vector.
  assign gnt    = pick & (~pick + N'(1));
  assign any    = |req;

endmodule

// File: rtl/cpri_rx_sched.sv
// CPRI receive-lane scheduler: grants one lane per chip and tags the lane read data.
// Define CPRI_RX_SCHED_ALIGN_EN for aligned rounds (all masked lanes ready, ascending order).
module cpri_rx_sched
  import cpri_rx_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CHIP_LEN  = CHIP_LEN_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_rx_enable,
  input  logic [NUM_LANES-1:0]         i_lane_mask,
  input  logic [NUM_LANES-1:0]         i_lane_vld,
  input  logic                         i_dn_ready,
  output logic [NUM_LANES-1:0]         o_lane_rready,
  output logic [$clog2(NUM_LANES)-1:0] o_sel_lane,
  output logic                         o_tvalid,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic [BEAT_W-1:0]            o_beat_idx,
  output logic                         o_busy,
  output logic [31:0]                  o_chip_cnt
);

  localparam int IDX_W = $clog2(NUM_LANES);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CHIP_LEN - 1);
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_CYC - 1);

  typedef struct packed {
    logic              vld;
    logic              sop;
    logic              eop;
    logic [BEAT_W-1:0] idx;
    logic [IDX_W-1:0]  sel;
  } beat_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [BEAT_W-1:0]  beat_reg, beat_next;
  logic [7:0]         gap_reg, gap_next;
  logic [31:0]        chip_cnt_reg, chip_cnt_next;

  logic [NUM_LANES-1:0] arb_req;
  logic [NUM_LANES-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_ptr;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [NUM_LANES-1:0] rready;
  logic                 last_beat;
  beat_t                stage_in;
  beat_t                pipe_out;

`ifdef CPRI_RX_SCHED_ALIGN_EN
  logic [NUM_LANES-1:0] pend_reg, pend_next;
  logic                 round_open;

  // A new round opens only when every masked lane holds a chip; within a round
  // the pointer is pinned so pending lanes are served lowest index first.
  always_comb begin
    round_open = (i_lane_mask != '0) && ((i_lane_mask & i_lane_vld) == i_lane_mask);
    if (pend_reg != '0) begin
      arb_req = pend_reg & i_lane_mask;
    end else if (round_open) begin
      arb_req = i_lane_mask;
    end else begin
      arb_req = '0;
    end
    arb_ptr = IDX_W'(NUM_LANES - 1);
  end

  always_comb begin
    pend_next = pend_reg;
    if (state_reg == ST_ARB && i_rx_enable) begin
      pend_next = arb_any ? (arb_req & ~arb_gnt) : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end
`else
  always_comb begin
    arb_req = i_lane_mask & i_lane_vld;
    arb_ptr = ptr_reg;
  end
`endif

  rr_arbiter #(
    .N  (NUM_LANES),
    .IW (IDX_W)
  ) u_arb (
    .req  (arb_req),
    .last (arb_ptr),
    .gnt  (arb_gnt),
    .any  (arb_any)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (arb_gnt[i]) begin
        arb_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_next    = grant_reg;
    beat_next     = beat_reg;
    gap_next      = gap_reg;
    chip_cnt_next = chip_cnt_reg;
    rready        = '0;
    last_beat     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_rx_enable) begin
          state_next = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!i_rx_enable) begin
          state_next = ST_IDLE;
        end else if (arb_any) begin
          grant_next = arb_idx;
          ptr_next   = arb_idx;
          beat_next  = '0;
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        rready[grant_reg] = i_dn_ready;
        if (i_dn_ready) begin
          if (beat_reg == BEAT_LAST) begin
            last_beat     = 1'b1;
            beat_next     = '0;
            gap_next      = '0;
            chip_cnt_next = chip_cnt_reg + 32'd1;
            state_next    = ST_GAP;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = i_rx_enable ? ST_ARB : ST_IDLE;
        end else begin
          gap_next = gap_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= IDX_W'(NUM_LANES - 1);
      grant_reg    <= '0;
      beat_reg     <= '0;
      gap_reg      <= '0;
      chip_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      grant_reg    <= grant_next;
      beat_reg     <= beat_next;
      gap_reg      <= gap_next;
      chip_cnt_reg <= chip_cnt_next;
    end
  end

  // Tags are zeroed on idle cycles so the data path sees clean sideband.
  always_comb begin
    stage_in     = '0;
    stage_in.vld = |rready;
    stage_in.sop = (|rready) && (beat_reg == '0);
    stage_in.eop = last_beat;
    if (|rready) begin
      stage_in.idx = beat_reg;
      stage_in.sel = grant_reg;
    end
  end

  // Never flushed on grant change: each beat carries its own lane tag.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
    beat_t stage_reg;
    if (gi == 0) begin : g_head
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= stage_in;
        end
      end
    end else begin : g_tail
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= g_pipe[gi-1].stage_reg;
        end
      end
    end
  end

  assign pipe_out = g_pipe[RD_LAT-1].stage_reg;

  // Outputs are forced low while reset is held, even before the first reset edge.
  assign o_lane_rready = i_reset ? '0 : rready;
  assign o_tvalid      = !i_reset && pipe_out.vld;
  assign o_sop         = !i_reset && pipe_out.sop;
  assign o_eop         = !i_reset && pipe_out.eop;
  assign o_beat_idx    = i_reset ? '0 : pipe_out.idx;
  assign o_sel_lane    = i_reset ? '0 : pipe_out.sel;
  assign o_busy        = !i_reset && (state_reg != ST_IDLE);
  assign o_chip_cnt    = i_reset ? '0 : chip_cnt_reg;

endmodule

// File: tb/tb_cpri_rx_sched.sv
// Directed self-checking bench for cpri_rx_sched (default and CPRI_RX_SCHED_ALIGN_EN builds).
module tb_cpri_rx_sched;

  localparam int RL = 3;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_rx_enable = 1'b0;
  logic [3:0]  i_lane_mask = 4'b0000;
  logic [3:0]  i_lane_vld = 4'b0000;
  logic        i_dn_ready = 1'b0;
  logic [3:0]  o_lane_rready;
  logic [1:0]  o_sel_lane;
  logic        o_tvalid;
  logic        o_sop;
  logic        o_eop;
  logic [6:0]  o_beat_idx;
  logic        o_busy;
  logic [31:0] o_chip_cnt;

  int n_cmp = 0;
  int n_err = 0;

  int gr[16];
  int gr_cyc[16];
  int ngr;
  int sop_cyc[16];
  int sop_sel[16];
  int nsop;
  int eop_cyc[16];
  int neop;
  int nbeats;
  int lane_beats[4];
  int idx_err;

  always #5 i_clk = ~i_clk;

  cpri_rx_sched #(
    .NUM_LANES (4),
    .CHIP_LEN  (84),
    .RD_LAT    (3),
    .GAP_CYC   (2)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_enable   (i_rx_enable),
    .i_lane_mask   (i_lane_mask),
    .i_lane_vld    (i_lane_vld),
    .i_dn_ready    (i_dn_ready),
    .o_lane_rready (o_lane_rready),
    .o_sel_lane    (o_sel_lane),
    .o_tvalid      (o_tvalid),
    .o_sop         (o_sop),
    .o_eop         (o_eop),
    .o_beat_idx    (o_beat_idx),
    .o_busy        (o_busy),
    .o_chip_cnt    (o_chip_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_bits();
    return 32'({o_lane_rready, o_sel_lane, o_tvalid, o_sop, o_eop, o_beat_idx, o_busy});
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    int r = -1;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic do_reset(input string tag);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    chk({tag, "_in_rst_out"}, out_bits(), 32'd0);
    chk({tag, "_in_rst_cnt"}, o_chip_cnt, 32'd0);
    i_reset = 1'b0;
    #1;
    chk({tag, "_post_rst_out"}, out_bits(), 32'd0);
    chk({tag, "_post_rst_cnt"}, o_chip_cnt, 32'd0);
  endtask

  // Runs the scheduler, recording grants/beats; drops enable at the max_gr-th grant.
  task automatic capture(input int max_gr, input bit toggle, input bit clr1, input int rst_at);
    int cyc = 0;
    int quiet = 0;
    int l1rd = 0;
    int rd_beats = 0;
    bit in_chip = 0;
    bit rst_done = 0;
    logic [6:0] exp_idx = '0;
    ngr = 0; nsop = 0; neop = 0; nbeats = 0; idx_err = 0;
    for (int i = 0; i < 4; i++) lane_beats[i] = 0;
    i_rx_enable = 1'b1;
    while (cyc < 3000) begin
      @(negedge i_clk);
      cyc++;
      if (o_lane_rready != '0) begin
        if (!in_chip && ngr < 16) begin
          gr[ngr] = oh2i(o_lane_rready);
          gr_cyc[ngr] = cyc;
          ngr++;
          if (ngr == max_gr) i_rx_enable = 1'b0;
        end
        in_chip = 1;
        rd_beats++;
        if (rd_beats == 84) begin
          in_chip = 0;
          rd_beats = 0;
        end
      end
      if (o_lane_rready[1]) l1rd++;
      if (clr1 && l1rd == 10) i_lane_mask = 4'b1101;
      if (o_tvalid) begin
        nbeats++;
        lane_beats[o_sel_lane]++;
        if (o_sop) begin
          exp_idx = '0;
          if (nsop < 16) begin
            sop_cyc[nsop] = cyc;
            sop_sel[nsop] = int'(o_sel_lane);
            nsop++;
          end
        end
        if (o_beat_idx !== exp_idx) idx_err++;
        exp_idx = exp_idx + 7'd1;
        if (o_eop && neop < 16) begin
          eop_cyc[neop] = cyc;
          neop++;
        end
      end
      if (toggle) i_dn_ready = ~i_dn_ready;
      if (rst_at >= 0 && !rst_done && o_tvalid && o_beat_idx == 7'(rst_at)) begin
        rst_done = 1;
        i_reset = 1'b1;
        #1;
        chk("midrst_during_out", out_bits(), 32'd0);
        @(negedge i_clk);
        cyc++;
        i_reset = 1'b0;
        #1;
        chk("midrst_after_out", out_bits(), 32'd0);
        chk("midrst_after_cnt", o_chip_cnt, 32'd0);
        in_chip = 0;
        rd_beats = 0;
      end
      quiet = (o_busy || o_tvalid) ? 0 : quiet + 1;
      if (!i_rx_enable && quiet > RL + 1) break;
    end
    chk("capture_terminated", 32'(quiet > RL + 1), 32'd1);
  endtask

  initial begin
    // Reset state
    i_lane_mask = 4'b1111;
    i_lane_vld  = 4'b1111;
    i_dn_ready  = 1'b1;
    do_reset("init");

    // All lanes ready, downstream always ready: grants 0,1,2,3,0
    capture(5, 0, 0, -1);
    chk("a_ngr", 32'(ngr), 32'd5);
    chk("a_gr0", 32'(gr[0]), 32'd0);
    chk("a_gr1", 32'(gr[1]), 32'd1);
    chk("a_gr2", 32'(gr[2]), 32'd2);
    chk("a_gr3", 32'(gr[3]), 32'd3);
    chk("a_gr4", 32'(gr[4]), 32'd0);
    chk("a_sop_lat", 32'(sop_cyc[0] - gr_cyc[0]), 32'd3);
    chk("a_chip_span", 32'(eop_cyc[0] - sop_cyc[0]), 32'd83);
    // GAP_CYC idle cycles plus the registered arbitration cycle
    chk("a_gap_idle", 32'(sop_cyc[1] - eop_cyc[0] - 1), 32'd3);
    chk("a_sel0", 32'(sop_sel[0]), 32'd0);
    chk("a_sel1", 32'(sop_sel[1]), 32'd1);
    chk("a_sel2", 32'(sop_sel[2]), 32'd2);
    chk("a_sel3", 32'(sop_sel[3]), 32'd3);
    chk("a_sel4", 32'(sop_sel[4]), 32'd0);
    chk("a_beats", 32'(nbeats), 32'd420);
    chk("a_idx_err", 32'(idx_err), 32'd0);
    chk("a_neop", 32'(neop), 32'd5);
    chk("a_chip_cnt", o_chip_cnt, 32'd5);
    chk("a_idle_busy", 32'(o_busy), 32'd0);

    // Downstream ready toggling: one chip, beats two cycles apart
    do_reset("b");
    i_dn_ready = 1'b1;
    capture(1, 1, 0, -1);
    i_dn_ready = 1'b1;
    chk("b_gr0", 32'(gr[0]), 32'd0);
    chk("b_span", 32'(eop_cyc[0] - sop_cyc[0]), 32'd166);
    chk("b_beats", 32'(nbeats), 32'd84);
    chk("b_idx_err", 32'(idx_err), 32'd0);
    chk("b_neop", 32'(neop), 32'd1);
    chk("b_chip_cnt", o_chip_cnt, 32'd1);

`ifndef CPRI_RX_SCHED_ALIGN_EN
    // Only lane 2 holds chips: served back to back
    do_reset("c");
    i_lane_vld = 4'b0100;
    capture(3, 0, 0, -1);
    chk("c_gr0", 32'(gr[0]), 32'd2);
    chk("c_gr1", 32'(gr[1]), 32'd2);
    chk("c_gr2", 32'(gr[2]), 32'd2);
    chk("c_chip_cnt", o_chip_cnt, 32'd3);

    // Lane 1 masked off mid-chip: chip completes, lane 1 skipped afterwards
    do_reset("d");
    i_lane_vld  = 4'b1111;
    i_lane_mask = 4'b1111;
    capture(6, 0, 1, -1);
    chk("d_gr0", 32'(gr[0]), 32'd0);
    chk("d_gr1", 32'(gr[1]), 32'd1);
    chk("d_gr2", 32'(gr[2]), 32'd2);
    chk("d_gr3", 32'(gr[3]), 32'd3);
    chk("d_gr4", 32'(gr[4]), 32'd0);
    chk("d_gr5", 32'(gr[5]), 32'd2);
    chk("d_lane1_beats", 32'(lane_beats[1]), 32'd84);
    chk("d_chip_cnt", o_chip_cnt, 32'd6);
`else
    // Aligned rounds: no grant until every masked lane is ready
    do_reset("al");
    i_lane_vld  = 4'b0111;
    i_lane_mask = 4'b1111;
    i_rx_enable = 1'b1;
    begin
      int hits = 0;
      repeat (50) begin
        @(negedge i_clk);
        if (o_lane_rready != '0) hits++;
      end
      chk("al_no_grant", 32'(hits), 32'd0);
      chk("al_busy_arb", 32'(o_busy), 32'd1);
    end
    i_lane_vld = 4'b1111;
    capture(4, 0, 0, -1);
    chk("al_gr0", 32'(gr[0]), 32'd0);
    chk("al_gr1", 32'(gr[1]), 32'd1);
    chk("al_gr2", 32'(gr[2]), 32'd2);
    chk("al_gr3", 32'(gr[3]), 32'd3);
    chk("al_chip_cnt", o_chip_cnt, 32'd4);
`endif

    // Reset pulse at output beat 40: aborted chip never shows eop; restart on lane 0
    do_reset("e");
    i_lane_vld  = 4'b1111;
    i_lane_mask = 4'b1111;
    i_dn_ready  = 1'b1;
    capture(2, 0, 0, 40);
    chk("e_gr0", 32'(gr[0]), 32'd0);
    chk("e_gr1", 32'(gr[1]), 32'd0);
    chk("e_nsop", 32'(nsop), 32'd2);
    chk("e_neop", 32'(neop), 32'd1);
    chk("e_beats", 32'(nbeats), 32'd125);
    chk("e_chip_cnt", o_chip_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
